// File: rtl/fust_g_table.sv
// Multi-row GEMM-unit status table: holds dispatched ops until all three operand tags clear, then issues oldest-first.
// Latency: dispatch -> visible next cycle; wakeup -> issue eligibility next cycle; outputs decoded from registered rows.
// Backpressure: disp_ready drops when every row is busy; a presented row is held until iss_ready. Optional: FUST_G_WAKE_BYPASS_EN.
module fust_g_table #(
  parameter int NROWS     = 4,
  parameter int TAG_W     = 2,
  parameter int PAYLOAD_W = 32,
  parameter int NWAKE     = 2
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [TAG_W-1:0]           disp_t1,
  input  logic [TAG_W-1:0]           disp_t2,
  input  logic [TAG_W-1:0]           disp_t3,
  input  logic                       disp_spec,
  input  logic [PAYLOAD_W-1:0]       disp_payload,
  input  logic [NWAKE-1:0]           wake_valid,
  input  logic [NWAKE*TAG_W-1:0]     wake_tag,
  output logic                       iss_valid,
  input  logic                       iss_ready,
  output logic [$clog2(NROWS)-1:0]   iss_row,
  output logic [PAYLOAD_W-1:0]       iss_payload,
  input  logic                       flush,
  input  logic                       resolved,
  output logic [$clog2(NROWS+1)-1:0] occupancy
);

  localparam int IDX_W = $clog2(NROWS);
  localparam int OCC_W = $clog2(NROWS+1);

  typedef struct packed {
    logic                 busy;
    logic                 spec;
    logic [TAG_W-1:0]     t1;
    logic [TAG_W-1:0]     t2;
    logic [TAG_W-1:0]     t3;
    logic [PAYLOAD_W-1:0] payload;
  } fust_g_row_t;

  fust_g_row_t [NROWS-1:0]            rows_q, rows_d;
  // older_q[i][j] set means row i was dispatched before row j
  logic [NROWS-1:0][NROWS-1:0]        older_q, older_d;

  logic [NROWS-1:0]  rdy;
  logic [NROWS-1:0]  oldest;
  logic              sel_vld;
  logic [IDX_W-1:0]  sel_idx;
  logic              free_vld;
  logic [IDX_W-1:0]  alloc_idx;
  logic              disp_fire;
  logic              iss_fire;
  logic [OCC_W-1:0]  occ_cnt;
  logic [TAG_W-1:0]  new_t1, new_t2, new_t3;

  // True when a nonzero tag matches any valid broadcast port this cycle
  function automatic logic woken(input logic [TAG_W-1:0]       t,
                                 input logic [NWAKE-1:0]       vld,
                                 input logic [NWAKE*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NWAKE; k++) begin
      if (vld[k] && (tags[k*TAG_W +: TAG_W] == t) && (t != '0)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Per-row readiness and oldest-ready detection from the age matrix
  always_comb begin
    logic [NROWS-1:0] blockers;
    rdy      = '0;
    oldest   = '0;
    blockers = '0;
    for (int i = 0; i < NROWS; i++) begin
      rdy[i] = rows_q[i].busy && (rows_q[i].t1 == '0) && (rows_q[i].t2 == '0) && (rows_q[i].t3 == '0);
    end
    for (int i = 0; i < NROWS; i++) begin
      blockers    = rdy & ~older_q[i];
      blockers[i] = 1'b0;
      oldest[i]   = rdy[i] && (blockers == '0);
    end
  end

  // Pick the issue candidate and the lowest free row (high-to-low scan so the lowest index wins)
  always_comb begin
    sel_vld   = 1'b0;
    sel_idx   = '0;
    free_vld  = 1'b0;
    alloc_idx = '0;
    for (int i = NROWS-1; i >= 0; i--) begin
      if (oldest[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
      if (!rows_q[i].busy) begin
        free_vld  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // Busy-row count straight from registered state, so it can never wrap
  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < NROWS; i++) begin
      occ_cnt = occ_cnt + {{(OCC_W-1){1'b0}}, rows_q[i].busy};
    end
  end

  assign disp_ready  = free_vld;
  assign iss_valid   = sel_vld && !flush;
  assign iss_row     = sel_idx;
  assign iss_payload = sel_vld ? rows_q[sel_idx].payload : '0;
  assign occupancy   = occ_cnt;

  // A speculative dispatch arriving with a flush would be squashed at once, so drop it
  assign disp_fire = disp_valid && free_vld && !(flush && disp_spec);
  assign iss_fire  = iss_valid && iss_ready;

  // Dispatch tags, optionally cleared by a wakeup in the same cycle
  always_comb begin
`ifdef FUST_G_WAKE_BYPASS_EN
    new_t1 = woken(disp_t1, wake_valid, wake_tag) ? '0 : disp_t1;
    new_t2 = woken(disp_t2, wake_valid, wake_tag) ? '0 : disp_t2;
    new_t3 = woken(disp_t3, wake_valid, wake_tag) ? '0 : disp_t3;
`else
    new_t1 = disp_t1;
    new_t2 = disp_t2;
    new_t3 = disp_t3;
`endif
  end

  // Next row state: issue/flush frees, wakeups clear tags, resolve clears spec, dispatch allocates
  always_comb begin
    rows_d  = rows_q;
    older_d = older_q;
    for (int i = 0; i < NROWS; i++) begin
      if (iss_fire && (sel_idx == IDX_W'(i))) rows_d[i].busy = 1'b0;
      if (flush && rows_q[i].spec)            rows_d[i].busy = 1'b0;
      if (woken(rows_q[i].t1, wake_valid, wake_tag)) rows_d[i].t1 = '0;
      if (woken(rows_q[i].t2, wake_valid, wake_tag)) rows_d[i].t2 = '0;
      if (woken(rows_q[i].t3, wake_valid, wake_tag)) rows_d[i].t3 = '0;
      if (resolved && !flush)                  rows_d[i].spec = 1'b0;
    end
    if (disp_fire) begin
      for (int i = 0; i < NROWS; i++) begin
        if (alloc_idx == IDX_W'(i)) begin
          rows_d[i].busy    = 1'b1;
          rows_d[i].spec    = disp_spec && !(resolved && !flush);
          rows_d[i].t1      = new_t1;
          rows_d[i].t2      = new_t2;
          rows_d[i].t3      = new_t3;
          rows_d[i].payload = disp_payload;
          older_d[i]        = '0;
        end else begin
          older_d[i][alloc_idx] = 1'b1;
        end
      end
    end
  end

  // Row and age-matrix registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rows_q  <= '0;
      older_q <= '0;
    end else begin
      rows_q  <= rows_d;
      older_q <= older_d;
    end
  end

endmodule

// File: tb/tb_fust_g_table.sv
// Randomised and directed checks of fust_g_table against a sequence-number reference model.
module tb_fust_g_table;
  localparam int N  = 4;
  localparam int TW = 2;
  localparam int PW = 32;
  localparam int NW = 2;

  logic           CLK = 1'b0;
  logic           nRST = 1'b0;
  logic           disp_valid = 1'b0;
  logic           disp_ready;
  logic [TW-1:0]  disp_t1 = '0, disp_t2 = '0, disp_t3 = '0;
  logic           disp_spec = 1'b0;
  logic [PW-1:0]  disp_payload = '0;
  logic [NW-1:0]  wake_valid = '0;
  logic [NW*TW-1:0] wake_tag = '0;
  logic           iss_valid;
  logic           iss_ready = 1'b0;
  logic [1:0]     iss_row;
  logic [PW-1:0]  iss_payload;
  logic           flush = 1'b0;
  logic           resolved = 1'b0;
  logic [2:0]     occupancy;

  fust_g_table #(.NROWS(N), .TAG_W(TW), .PAYLOAD_W(PW), .NWAKE(NW)) dut (
    .CLK(CLK), .nRST(nRST),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_t1(disp_t1), .disp_t2(disp_t2), .disp_t3(disp_t3),
    .disp_spec(disp_spec), .disp_payload(disp_payload),
    .wake_valid(wake_valid), .wake_tag(wake_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_row(iss_row), .iss_payload(iss_payload),
    .flush(flush), .resolved(resolved), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: each row remembers its dispatch sequence number; oldest = smallest number
  logic          m_busy [N];
  logic          m_spec [N];
  logic [TW-1:0] m_tag  [N][3];
  logic [PW-1:0] m_pay  [N];
  int            m_seq  [N];
  int            seq_ctr;

  bit e_full;
  bit e_found;
  int e_row;
  int e_alloc;

  function automatic bit wake_hit(input logic [TW-1:0] t);
    bit hit = 1'b0;
    for (int k = 0; k < NW; k++)
      if (t != 0 && wake_valid[k] && wake_tag[k*TW +: TW] == t) hit = 1'b1;
    return hit;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_spec[i] = 0; m_pay[i] = 0; m_seq[i] = 0;
      for (int k = 0; k < 3; k++) m_tag[i][k] = 0;
    end
    seq_ctr = 0;
  endtask

  // Drive one cycle of inputs at the falling edge and compare outputs with the model
  task automatic apply(input logic dv, input logic [TW-1:0] a, input logic [TW-1:0] b, input logic [TW-1:0] c,
                       input logic sp, input logic [PW-1:0] pay, input logic [NW-1:0] wv,
                       input logic [NW*TW-1:0] wt, input logic ir, input logic fl, input logic rs);
    int cnt;
    int best;
    @(negedge CLK);
    disp_valid = dv; disp_t1 = a; disp_t2 = b; disp_t3 = c; disp_spec = sp; disp_payload = pay;
    wake_valid = wv; wake_tag = wt; iss_ready = ir; flush = fl; resolved = rs;
    #1;
    cnt = 0; e_alloc = -1; e_found = 0; e_row = 0; best = 0;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) cnt++;
      else if (e_alloc < 0) e_alloc = i;
      if (m_busy[i] && m_tag[i][0] == 0 && m_tag[i][1] == 0 && m_tag[i][2] == 0) begin
        if (!e_found || m_seq[i] < best) begin
          e_found = 1; e_row = i; best = m_seq[i];
        end
      end
    end
    e_full = (cnt == N);
    chk("disp_ready", 64'(disp_ready), 64'(!e_full));
    chk("iss_valid", 64'(iss_valid), 64'(e_found && !fl));
    chk("occupancy", 64'(occupancy), 64'(cnt));
    if (e_found && !fl) begin
      chk("iss_row", 64'(iss_row), 64'(e_row));
      chk("iss_payload", 64'(iss_payload), 64'(m_pay[e_row]));
    end
  endtask

  // Advance the model by the rules for the inputs currently driven, then cross the rising edge
  task automatic commit();
    bit fire_d;
    fire_d = disp_valid && !e_full && !(flush && disp_spec);
    if (e_found && !flush && iss_ready) m_busy[e_row] = 0;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        if (flush && m_spec[i]) m_busy[i] = 0;
        for (int k = 0; k < 3; k++) if (wake_hit(m_tag[i][k])) m_tag[i][k] = 0;
        if (resolved && !flush) m_spec[i] = 0;
      end
    end
    if (fire_d) begin
      m_busy[e_alloc] = 1;
      m_spec[e_alloc] = disp_spec && !(resolved && !flush);
      m_tag[e_alloc][0] = disp_t1;
      m_tag[e_alloc][1] = disp_t2;
      m_tag[e_alloc][2] = disp_t3;
`ifdef FUST_G_WAKE_BYPASS_EN
      for (int k = 0; k < 3; k++) if (wake_hit(m_tag[e_alloc][k])) m_tag[e_alloc][k] = 0;
`endif
      m_pay[e_alloc] = disp_payload;
      m_seq[e_alloc] = seq_ctr;
      seq_ctr++;
    end
    @(posedge CLK);
  endtask

  task automatic step(input logic dv, input logic [TW-1:0] a, input logic [TW-1:0] b, input logic [TW-1:0] c,
                      input logic sp, input logic [PW-1:0] pay, input logic [NW-1:0] wv,
                      input logic [NW*TW-1:0] wt, input logic ir, input logic fl, input logic rs);
    apply(dv, a, b, c, sp, pay, wv, wt, ir, fl, rs);
    commit();
  endtask

  task automatic idle(input logic ir);
    step(0, 0, 0, 0, 0, 0, 0, 0, ir, 0, 0);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without a clock
  task automatic do_reset();
    #2;
    nRST = 1'b0;
    disp_valid = 0; wake_valid = 0; iss_ready = 0; flush = 0; resolved = 0;
    #1;
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_row", 64'(iss_row), 64'd0);
    chk("rst_iss_payload", 64'(iss_payload), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic exp_byp;
    model_reset();
    do_reset();

    // 1: single ready dispatch appears next cycle in row 0
    step(1, 0, 0, 0, 0, 32'hA5, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_iss_valid", 64'(iss_valid), 64'd1);
    chk("t1_iss_row", 64'(iss_row), 64'd0);
    chk("t1_iss_payload", 64'(iss_payload), 64'hA5);
    chk("t1_occupancy", 64'(occupancy), 64'd1);
    commit();

    // 2: fill with blocked rows, wake on port 1, drain in dispatch order
    do_reset();
    for (int r = 0; r < N; r++) step(1, 2, 0, 0, 0, 32'(100 + r), 0, 0, 0, 0, 0);
    apply(1, 0, 0, 0, 0, 32'hDEAD, 2'b10, 4'b1000, 0, 0, 0);
    chk("t2_full_ready", 64'(disp_ready), 64'd0);
    chk("t2_full_occ", 64'(occupancy), 64'd4);
    commit();
    for (int r = 0; r < N; r++) begin
      apply(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      chk("t2_order_valid", 64'(iss_valid), 64'd1);
      chk("t2_order_row", 64'(iss_row), 64'(r));
      commit();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_drained", 64'(occupancy), 64'd0);
    commit();

    // 3: row 1 older than a reallocated row 0
    do_reset();
    step(1, 0, 0, 0, 0, 32'd1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 32'd2, 0, 0, 0, 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 32'd3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 2'b01, 4'b0001, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t3_oldest_row", 64'(iss_row), 64'd1);
    chk("t3_oldest_pay", 64'(iss_payload), 64'd2);
    commit();

    // 4: flush removes spec rows and drops a spec dispatch
    do_reset();
    step(1, 1, 0, 0, 1, 32'd10, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 32'd11, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 32'd12, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'd13, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 2'b01, 4'b0001, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t4_occupancy", 64'(occupancy), 64'd1);
    chk("t4_iss_row", 64'(iss_row), 64'd1);
    chk("t4_iss_pay", 64'(iss_payload), 64'd11);
    commit();

    // 5: resolve then flush leaves rows intact
    do_reset();
    step(1, 1, 0, 0, 1, 32'd20, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1, 32'd21, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_occupancy", 64'(occupancy), 64'd2);
    commit();

    // 6: dispatch racing its own wakeup
    do_reset();
    step(1, 0, 3, 0, 0, 32'd30, 2'b01, 4'b0011, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FUST_G_WAKE_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    chk("t6_bypass", 64'(iss_valid), 64'(exp_byp));
    commit();

    // Random traffic with a mid-run asynchronous reset
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      step(($urandom % 10) < 6,
           ($urandom % 3 == 0) ? TW'($urandom % 4) : TW'(0),
           ($urandom % 3 == 0) ? TW'($urandom % 4) : TW'(0),
           ($urandom % 4 == 0) ? TW'($urandom % 4) : TW'(0),
           ($urandom % 4) == 0, $urandom,
           NW'($urandom), (NW*TW)'($urandom),
           ($urandom % 10) < 7, ($urandom % 20) == 0, ($urandom % 10) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
